// File: rtl/col_scheduler_if.sv
// Read-request channel from col_scheduler (master) to the frame-buffer read path (slave).
interface col_scheduler_if #(
  parameter int unsigned THETA_RES = 27,
  parameter int unsigned NUM_COLS  = 64
);
  localparam int unsigned CW = $clog2(NUM_COLS);

  logic                 req_valid_out;
  logic                 req_ready_in;
  logic [CW-1:0]        req_col_out;
  logic [THETA_RES-1:0] req_theta_out;

  modport master (
    output req_valid_out,
    output req_col_out,
    output req_theta_out,
    input  req_ready_in
  );

  modport slave (
    input  req_valid_out,
    input  req_col_out,
    input  req_theta_out,
    output req_ready_in
  );
endinterface

// File: rtl/col_scheduler.sv
// Per-slice column sequencer: issues one read request per enabled column, lowest first.
// Optional COL_SCHED_DROP_CNT_EN builds a saturating count of overwritten pending slices.
module col_scheduler #(
  parameter int unsigned THETA_RES = 27,
  parameter int unsigned NUM_COLS  = 64
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [THETA_RES-1:0] theta_in,
  input  logic                 theta_valid_in,
  input  logic [NUM_COLS-1:0]  col_en_in,
  col_scheduler_if.master      req,
  output logic                 slice_done_out,
  output logic                 busy_out,
  output logic [15:0]          drop_count_out
);
  localparam int unsigned CW = $clog2(NUM_COLS);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e               state_q, state_d;
  logic [THETA_RES-1:0] theta_q, theta_d;
  logic [NUM_COLS-1:0]  mask_q, mask_d;
  logic [CW-1:0]        cursor_q, cursor_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [THETA_RES-1:0] pend_theta_q, pend_theta_d;
  logic [NUM_COLS-1:0]  pend_mask_q, pend_mask_d;
  logic                 drop_evt;
  logic                 found;
  logic [CW-1:0]        scan_col;
  logic                 hs;

  // Lowest enabled column at or above the cursor.
  always_comb begin
    found    = 1'b0;
    scan_col = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!found && mask_q[i] && (CW'(i) >= cursor_q)) begin
        found    = 1'b1;
        scan_col = CW'(i);
      end
    end
  end

  assign hs = req.req_valid_out && req.req_ready_in;

  always_comb begin
    state_d      = state_q;
    theta_d      = theta_q;
    mask_d       = mask_q;
    cursor_d     = cursor_q;
    pend_valid_d = pend_valid_q;
    pend_theta_d = pend_theta_q;
    pend_mask_d  = pend_mask_q;
    drop_evt     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An empty mask still passes through one scan cycle before DONE.
        if (theta_valid_in) begin
          theta_d  = theta_in;
          mask_d   = col_en_in;
          cursor_d = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        if (theta_valid_in) begin
          pend_valid_d = 1'b1;
          pend_theta_d = theta_in;
          pend_mask_d  = col_en_in;
          drop_evt     = pend_valid_q;
        end
        if (hs) begin
          mask_d[scan_col] = 1'b0;
          cursor_d         = scan_col + CW'(1);
        end
        if (mask_d == '0) state_d = StDone;
      end
      StDone: begin
        pend_valid_d = 1'b0;
        if (theta_valid_in || pend_valid_q) begin
          // A fresh theta beats the stale pending entry, which is then counted as dropped.
          drop_evt = theta_valid_in && pend_valid_q;
          if (theta_valid_in) begin
            theta_d = theta_in;
            mask_d  = col_en_in;
          end else begin
            theta_d = pend_theta_q;
            mask_d  = pend_mask_q;
          end
          cursor_d = '0;
          state_d  = (mask_d == '0) ? StDone : StScan;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      theta_q      <= '0;
      mask_q       <= '0;
      cursor_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_theta_q <= '0;
      pend_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      theta_q      <= theta_d;
      mask_q       <= mask_d;
      cursor_q     <= cursor_d;
      pend_valid_q <= pend_valid_d;
      pend_theta_q <= pend_theta_d;
      pend_mask_q  <= pend_mask_d;
    end
  end

  assign req.req_valid_out = (state_q == StScan) && found;
  assign req.req_col_out   = (state_q == StScan) ? scan_col : '0;
  assign req.req_theta_out = theta_q;
  assign slice_done_out    = (state_q == StDone);
  assign busy_out          = (state_q != StIdle);

`ifdef COL_SCHED_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      drop_cnt_q <= '0;
    end else if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count_out = drop_cnt_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
  assign drop_count_out  = '0;
`endif
endmodule

// File: tb/tb_col_scheduler.sv
// Self-checking bench for col_scheduler: slice-level queue model plus directed literal checks.
module tb_col_scheduler;
  localparam int unsigned TR = 27;
  localparam int unsigned NC = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TR-1:0] theta;
  logic          tv;
  logic [NC-1:0] mask;
  logic          ready;
  logic          done;
  logic          busy;
  logic [15:0]   drops;

  always #5 clk = ~clk;

  col_scheduler_if #(.THETA_RES(TR), .NUM_COLS(NC)) rif ();
  assign rif.req_ready_in = ready;

  col_scheduler #(.THETA_RES(TR), .NUM_COLS(NC)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .theta_in       (theta),
    .theta_valid_in (tv),
    .col_en_in      (mask),
    .req            (rif),
    .slice_done_out (done),
    .busy_out       (busy),
    .drop_count_out (drops)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Slice-level model: 0 idle, 1 scanning, 2 done; columns kept as an ordered queue.
  int            m_phase;
  int            m_cols[$];
  logic [TR-1:0] m_theta;
  bit            m_pend;
  logic [TR-1:0] m_pt;
  logic [NC-1:0] m_pm;
  int            m_drops;
  bit            m_hs;
  int            cyc = 0;

  function automatic void load_slice(input logic [TR-1:0] t, input logic [NC-1:0] m);
    m_theta = t;
    m_cols.delete();
    for (int i = 0; i < NC; i++) if (m[i]) m_cols.push_back(i);
  endfunction

  function automatic void note_drop();
`ifdef COL_SCHED_DROP_CNT_EN
    if (m_drops < 65535) m_drops++;
`endif
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cols.delete();
      m_theta = '0;
      m_pend  = 1'b0;
      m_pt    = '0;
      m_pm    = '0;
      m_drops = 0;
    end else begin
      m_hs = (m_phase == 1) && (m_cols.size() > 0) && ready;
      case (m_phase)
        0: if (tv) begin
          load_slice(theta, mask);
          m_phase = 1;
        end
        1: begin
          if (tv) begin
            if (m_pend) note_drop();
            m_pend = 1'b1;
            m_pt   = theta;
            m_pm   = mask;
          end
          if (m_hs) void'(m_cols.pop_front());
          if (m_cols.size() == 0) m_phase = 2;
        end
        default: begin
          if (tv || m_pend) begin
            if (tv && m_pend) note_drop();
            if (tv) load_slice(theta, mask);
            else    load_slice(m_pt, m_pm);
            m_pend  = 1'b0;
            m_phase = (m_cols.size() == 0) ? 2 : 1;
          end else begin
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Observation logs for the directed checks.
  int            acc_col[$];
  logic [TR-1:0] acc_theta[$];
  int            acc_cyc[$];
  int            done_cyc[$];
  int            n_valid;
  bit            prev_valid;
  bit            prev_ready;
  int            prev_col;
  logic [TR-1:0] prev_theta;
  bit            exp_valid;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_valid = (m_phase == 1) && (m_cols.size() > 0);
      check("req_valid", 64'(rif.req_valid_out), 64'(exp_valid));
      if (exp_valid) begin
        check("req_col", 64'(rif.req_col_out), 64'(m_cols[0]));
        check("req_theta", 64'(rif.req_theta_out), 64'(m_theta));
      end
      check("slice_done", 64'(done), 64'(m_phase == 2));
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("drop_count", 64'(drops), 64'(m_drops));
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(rif.req_valid_out), 64'd1);
        check("hold_col", 64'(rif.req_col_out), 64'(prev_col));
        check("hold_theta", 64'(rif.req_theta_out), 64'(prev_theta));
      end
      if (rif.req_valid_out && ready) begin
        acc_col.push_back(int'(rif.req_col_out));
        acc_theta.push_back(rif.req_theta_out);
        acc_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (rif.req_valid_out) n_valid++;
      prev_valid = rif.req_valid_out;
      prev_ready = ready;
      prev_col   = int'(rif.req_col_out);
      prev_theta = rif.req_theta_out;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [TR-1:0] t, input logic [NC-1:0] m);
    tv    = 1'b1;
    theta = t;
    mask  = m;
    tick(1);
    tv    = 1'b0;
  endtask

  task automatic clear_logs();
    acc_col.delete();
    acc_theta.delete();
    acc_cyc.delete();
    done_cyc.delete();
    n_valid = 0;
  endtask

  int n0;
  int exp_c4[6] = '{4, 5, 6, 7, 0, 2};
  int exp_t4[6] = '{'hA, 'hA, 'hA, 'hA, 'hC, 'hC};

  initial begin
    tv    = 1'b0;
    theta = '0;
    mask  = '0;
    ready = 1'b0;
    rst_n = 1'b1;
    n_valid = 0;
    #2 rst_n = 1'b0;
    tick(2);
    check("rst_valid", 64'(rif.req_valid_out), 64'd0);
    check("rst_col", 64'(rif.req_col_out), 64'd0);
    check("rst_theta", 64'(rif.req_theta_out), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drops", 64'(drops), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Full mask, back-to-back.
    clear_logs();
    ready = 1'b1;
    n0 = cyc;
    pulse(27'h123, {NC{1'b1}});
    tick(70);
    check("full_count", 64'(acc_col.size()), 64'd64);
    if (acc_col.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        check("full_col", 64'(acc_col[i]), 64'(i));
        check("full_theta", 64'(acc_theta[i]), 64'h123);
        check("full_cyc", 64'(acc_cyc[i]), 64'(n0 + 1 + i));
      end
    end
    check("full_done_n", 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() == 1) check("full_done_cyc", 64'(done_cyc[0]), 64'(n0 + 65));
    check("full_idle", 64'(busy), 64'd0);

    // Sparse mask, ready toggling.
    clear_logs();
    ready = 1'b0;
    pulse(27'h2AB, 64'h8000_0000_0000_0011);
    for (int i = 0; i < 20; i++) begin
      ready = !ready;
      tick(1);
    end
    check("sparse_count", 64'(acc_col.size()), 64'd3);
    if (acc_col.size() == 3) begin
      check("sparse_c0", 64'(acc_col[0]), 64'd0);
      check("sparse_c1", 64'(acc_col[1]), 64'd4);
      check("sparse_c2", 64'(acc_col[2]), 64'd63);
      check("sparse_theta", 64'(acc_theta[2]), 64'h2AB);
      check("sparse_done_n", 64'(done_cyc.size()), 64'd1);
      if (done_cyc.size() == 1) check("sparse_done", 64'(done_cyc[0]), 64'(acc_cyc[2] + 1));
    end

    // Empty mask.
    clear_logs();
    ready = 1'b1;
    n0 = cyc;
    pulse(27'h3C, '0);
    tick(6);
    check("empty_nvalid", 64'(n_valid), 64'd0);
    check("empty_done_n", 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() == 1) check("empty_done_cyc", 64'(done_cyc[0]), 64'(n0 + 2));
    check("empty_idle", 64'(busy), 64'd0);

    // A, B, C during one scan: B is overwritten by C.
    clear_logs();
    n0 = cyc;
    pulse(27'hA, 64'hF0);
    pulse(27'hB, 64'h3);
    pulse(27'hC, 64'h5);
    tick(15);
    check("abc_count", 64'(acc_col.size()), 64'd6);
    if (acc_col.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("abc_col", 64'(acc_col[i]), 64'(exp_c4[i]));
        check("abc_theta", 64'(acc_theta[i]), 64'(exp_t4[i]));
      end
      check("abc_c_first", 64'(acc_cyc[4]), 64'(n0 + 6));
    end
    check("abc_done_n", 64'(done_cyc.size()), 64'd2);
    if (done_cyc.size() == 2) check("abc_done_a", 64'(done_cyc[0]), 64'(n0 + 5));
`ifdef COL_SCHED_DROP_CNT_EN
    check("abc_drops", 64'(drops), 64'd1);
`else
    check("abc_drops", 64'(drops), 64'd0);
`endif

    // Reset with column 10 outstanding.
    clear_logs();
    ready = 1'b1;
    pulse(27'h55, {NC{1'b1}});
    tick(10);
    ready = 1'b0;
    tick(2);
    check("mid_count", 64'(acc_col.size()), 64'd10);
    check("mid_valid", 64'(rif.req_valid_out), 64'd1);
    check("mid_col", 64'(rif.req_col_out), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(rif.req_valid_out), 64'd0);
    check("arst_col", 64'(rif.req_col_out), 64'd0);
    check("arst_theta", 64'(rif.req_theta_out), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    tick(2);
    rst_n = 1'b1;
    ready = 1'b1;
    n_valid = 0;
    tick(10);
    check("post_nvalid", 64'(n_valid), 64'd0);
    check("post_busy", 64'(busy), 64'd0);

`ifdef COL_SCHED_DROP_CNT_EN
    // Stall a scan and overwrite the pending slot every cycle.
    ready = 1'b0;
    tv    = 1'b1;
    theta = 27'h1;
    mask  = {NC{1'b1}};
    tick(65540);
    tv = 1'b0;
    check("sat_drops", 64'(drops), 64'hFFFF);
    tick(1);
    check("sat_hold", 64'(drops), 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
